mmio_store_sink: RTL

Memory-mapped store responder on the processor data-write interface (MemWrite/DataAdr/WriteData).
- Decodes a 16-byte window and captures DATA stores into a FIFO, drained over a valid/ready stream.
- Latches a DONE/exit code.
- Gives the simulation environment and on-chip checkers a structured consumer for program output, replacing ad-hoc probing of the data bus.

---
 rtl/mmio_store_sink.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mmio_store_sink.sv
// mmio_store_sink
// Memory-mapped store responder on the core's data-write interface.
// A 16-byte window at BASE_ADDR holds four word registers:
//   +0x0 DATA  : push WriteData into a first-word-fall-through FIFO
//   +0x4 DONE  : first write sets done and latches exit_code
//   +0x8 CLEAR : flush FIFO, clear overflow and store_count
//   +0xC reserved
// Ports:
//   clk, reset (sync, active-low)
//   MemWrite, DataAdr, WriteData      : core store interface
//   out_valid, out_ready, out_data    : FIFO drain stream
//   fifo_level                        : current occupancy
//   overflow                          : sticky, a DATA store was dropped
//   store_count                       : accepted DATA stores, saturating
//   done, exit_code                   : sticky completion flag and code
// Optional macro STORE_SINK_TIMESTAMP_EN adds out_ts: the free-running cycle
// count captured when the head entry was pushed.
module mmio_store_sink #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [31:0]              DataAdr,
  input  logic [31:0]              WriteData,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         store_count,
  output logic                     done,
  output logic [31:0]              exit_code
`ifdef STORE_SINK_TIMESTAMP_EN
  ,
  output logic [31:0]              out_ts
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    REG_DATA  = 2'd0,
    REG_DONE  = 2'd1,
    REG_CLEAR = 2'd2,
    REG_RSVD  = 2'd3
  } regSel_t;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] level;

  logic          hit;
  regSel_t       regSel;
  logic          isData;
  logic          isDone;
  logic          isClear;
  logic          pop;
  logic          full;
  logic          pushOk;
  logic          pushDrop;

  // Decode
  always_comb begin
    hit      = MemWrite && (DataAdr[31:4] == BASE_ADDR[31:4]) && (DataAdr[1:0] == 2'b00);
    regSel   = regSel_t'(DataAdr[3:2]);
    isData   = hit && (regSel == REG_DATA);
    isDone   = hit && (regSel == REG_DONE);
    isClear  = hit && (regSel == REG_CLEAR);
    level    = wrPtr - rdPtr;
    full     = (level == PW'(DEPTH));
    pop      = out_valid && out_ready;
    // A simultaneous pop frees the slot, so a push to a full FIFO still lands.
    pushOk   = isData && (!full || pop);
    pushDrop = isData && full && !pop;
  end

  // FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (isClear) begin
      // Flush takes priority over any pop in the same cycle.
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (pushOk) begin
        mem[wrPtr[AW-1:0]] <= WriteData;
        wrPtr              <= wrPtr + PW'(1);
      end
      if (pop) rdPtr <= rdPtr + PW'(1);
    end
  end

  // Status counters and flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow    <= 1'b0;
      store_count <= '0;
      done        <= 1'b0;
      exit_code   <= '0;
    end else begin
      if (isClear) begin
        overflow    <= 1'b0;
        store_count <= '0;
      end else begin
        if (pushDrop) overflow <= 1'b1;
        if (pushOk && (store_count != '1)) store_count <= store_count + CNT_W'(1);
      end
      if (isDone && !done) begin
        done      <= 1'b1;
        exit_code <= WriteData;
      end
    end
  end

  always_comb begin
    out_valid  = (wrPtr != rdPtr);
    out_data   = out_valid ? mem[rdPtr[AW-1:0]] : '0;
    fifo_level = level;
  end

`ifdef STORE_SINK_TIMESTAMP_EN
  logic [31:0] cycleCnt;
  logic [31:0] tsMem [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      cycleCnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) tsMem[i] <= '0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
      if (pushOk && !isClear) tsMem[wrPtr[AW-1:0]] <= cycleCnt;
    end
  end

  always_comb begin
    out_ts = out_valid ? tsMem[rdPtr[AW-1:0]] : '0;
  end
`endif

endmodule
